// File: rtl/mem_region_mpu.sv
// Region-based memory protection unit between a cpu request port and a single-port SRAM.
// Each region pairs a code window (who may access) with a data window and R/W/X permissions.
module mem_region_mpu #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned ADDR_WIDTH  = 22,
    parameter int unsigned NUM_REGIONS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_valid,
    input  logic                  cpu_instr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_wstrb,
    input  logic [31:0]           pc_addr,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    output logic [3:0]            mem_wen,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  cfg_valid,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    output logic                  cfg_ready,
    output logic                  irq
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StMem   = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [32:0] MemBytes = 33'(MEM_WORDS) << 2;

    logic [1:0]  state_q, state_d;
    logic [31:0] code_lo_q [NUM_REGIONS];
    logic [31:0] code_hi_q [NUM_REGIONS];
    logic [31:0] data_lo_q [NUM_REGIONS];
    logic [31:0] data_hi_q [NUM_REGIONS];
    logic [4:0]  ctrl_q    [NUM_REGIONS];
    logic        fault_q;
    logic [1:0]  ftype_q;
    logic [31:0] fault_addr_q, fault_pc_q;
    logic        mpu_en_q;
    logic        allowed_q;
    logic        cfg_ready_q;
    logic [31:0] cfg_rdata_q;

    logic [31:0] addr_ext, code_pt, cfg_rd_c;
    logic        in_mem, is_write, code_hit_any, region_ok, allow_c;
    logic [1:0]  ftype_c;
    logic        cfg_wr, fault_set, status_clr;

    assign addr_ext = 32'(cpu_addr);
    assign code_pt  = cpu_instr ? addr_ext : pc_addr;
    assign in_mem   = {1'b0, addr_ext} < MemBytes;
    assign is_write = cpu_wstrb != 4'h0;

    // Region results are ORed; a fetch needs only the code window, data needs both windows.
    always_comb begin
        code_hit_any = 1'b0;
        region_ok    = 1'b0;
        for (int r = 0; r < int'(NUM_REGIONS); r++) begin
            if (ctrl_q[r][0] && code_pt >= code_lo_q[r] && code_pt <= code_hi_q[r]) begin
                code_hit_any = 1'b1;
                if (cpu_instr ? ctrl_q[r][3]
                    : (addr_ext >= data_lo_q[r] && addr_ext <= data_hi_q[r] &&
                       (is_write ? ctrl_q[r][2] : ctrl_q[r][1]))) begin
                    region_ok = 1'b1;
                end
            end
        end
        allow_c = 1'b0;
        ftype_c = 2'd0;
        if (!in_mem) begin
            ftype_c = 2'd2;
        end else if (!mpu_en_q || region_ok) begin
            allow_c = 1'b1;
        end else begin
            ftype_c = code_hit_any ? 2'd1 : 2'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cpu_valid) state_d = StCheck;
            StCheck: state_d = allow_c ? StMem : StResp;
            StMem:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign cfg_wr     = cfg_valid && cfg_we;
    assign fault_set  = (state_q == StCheck) && !allow_c;
    assign status_clr = cfg_wr && (cfg_addr == 8'h80) && cfg_wdata[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            allowed_q    <= 1'b0;
            fault_q      <= 1'b0;
            ftype_q      <= 2'd0;
            fault_addr_q <= '0;
            fault_pc_q   <= '0;
            mpu_en_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == StCheck) allowed_q <= allow_c;
            // A new fault outranks a simultaneous clear; first fault keeps its capture.
            if (fault_set) begin
                fault_q <= 1'b1;
                if (!fault_q) begin
                    ftype_q      <= ftype_c;
                    fault_addr_q <= addr_ext;
                    fault_pc_q   <= pc_addr;
                end
            end else if (status_clr) begin
                fault_q <= 1'b0;
            end
            if (cfg_wr && cfg_addr == 8'h83) mpu_en_q <= cfg_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < int'(NUM_REGIONS); r++) begin
                code_lo_q[r] <= '0;
                code_hi_q[r] <= '0;
                data_lo_q[r] <= '0;
                data_hi_q[r] <= '0;
                ctrl_q[r]    <= '0;
            end
        end else if (cfg_wr && !cfg_addr[7]) begin
            for (int r = 0; r < int'(NUM_REGIONS); r++) begin
                if (cfg_addr[6:3] == 4'(r) && !ctrl_q[r][4]) begin
                    case (cfg_addr[2:0])
                        3'd0:    code_lo_q[r] <= cfg_wdata;
                        3'd1:    code_hi_q[r] <= cfg_wdata;
                        3'd2:    data_lo_q[r] <= cfg_wdata;
                        3'd3:    data_hi_q[r] <= cfg_wdata;
                        3'd4:    ctrl_q[r]    <= cfg_wdata[4:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        cfg_rd_c = '0;
        if (cfg_addr[7]) begin
            case (cfg_addr[6:0])
                7'h00:   cfg_rd_c = {29'b0, ftype_q, fault_q};
                7'h01:   cfg_rd_c = fault_addr_q;
                7'h02:   cfg_rd_c = fault_pc_q;
                7'h03:   cfg_rd_c = {31'b0, mpu_en_q};
                default: cfg_rd_c = '0;
            endcase
        end else begin
            for (int r = 0; r < int'(NUM_REGIONS); r++) begin
                if (cfg_addr[6:3] == 4'(r)) begin
                    case (cfg_addr[2:0])
                        3'd0:    cfg_rd_c = code_lo_q[r];
                        3'd1:    cfg_rd_c = code_hi_q[r];
                        3'd2:    cfg_rd_c = data_lo_q[r];
                        3'd3:    cfg_rd_c = data_hi_q[r];
                        3'd4:    cfg_rd_c = {27'b0, ctrl_q[r]};
                        default: cfg_rd_c = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_ready_q <= 1'b0;
            cfg_rdata_q <= '0;
        end else begin
            cfg_ready_q <= cfg_valid;
            cfg_rdata_q <= (cfg_valid && !cfg_we) ? cfg_rd_c : '0;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_rdata = cfg_rdata_q;
    assign irq       = fault_q;
    assign cpu_ready = state_q == StResp;
    assign cpu_rdata = (state_q == StResp && allowed_q && !is_write) ? mem_rdata : '0;
    assign mem_wen   = (state_q == StMem) ? cpu_wstrb : 4'h0;
    assign mem_addr  = (state_q == StMem) ? cpu_addr[ADDR_WIDTH-1:2] : '0;
    assign mem_wdata = (state_q == StMem) ? cpu_wdata : '0;

endmodule

// File: tb/tb_mem_region_mpu.sv
// Self-checking bench for mem_region_mpu: directed tables, hand sequences for reset and
// lock corners, and randomized accesses against a permission model built from region rules.
module tb_mem_region_mpu;
    localparam int unsigned MEM_WORDS   = 1024;
    localparam int unsigned ADDR_WIDTH  = 22;
    localparam int unsigned NUM_REGIONS = 8;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  cpu_valid, cpu_instr;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_wdata, pc_addr, cpu_rdata;
    logic [3:0]            cpu_wstrb, mem_wen;
    logic                  cpu_ready;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic [31:0]           mem_wdata, mem_rdata;
    logic                  cfg_valid, cfg_we, cfg_ready, irq;
    logic [7:0]            cfg_addr;
    logic [31:0]           cfg_wdata, cfg_rdata;

    always #5 clk = ~clk;

    mem_region_mpu #(
        .MEM_WORDS  (MEM_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGIONS(NUM_REGIONS)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cpu_valid(cpu_valid),
        .cpu_instr(cpu_instr),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb),
        .pc_addr  (pc_addr),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cfg_valid(cfg_valid),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .cfg_ready(cfg_ready),
        .irq      (irq)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'hC0DE0000 ^ 32'(i * 32'h00010003);
    endfunction

    // SRAM: one-cycle read latency, byte write enables
    bit          init_done;
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) sram[i] <= pattern(i);
            init_done <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= sram[mem_addr[9:0]];
    end

    // Reference state
    logic [31:0] m_clo [NUM_REGIONS];
    logic [31:0] m_chi [NUM_REGIONS];
    logic [31:0] m_dlo [NUM_REGIONS];
    logic [31:0] m_dhi [NUM_REGIONS];
    logic [4:0]  m_ctrl[NUM_REGIONS];
    bit          m_en, m_fault;
    logic [1:0]  m_type;
    logic [31:0] m_faddr, m_fpc;
    logic [31:0] exp_mem [0:1023];

    int          n_tests, n_fail;
    int          last_cyc;
    logic [3:0]  last_wen;
    logic [31:0] last_waddr, last_wdata, last_rdata;

    task automatic model_reset();
        for (int r = 0; r < int'(NUM_REGIONS); r++) begin
            m_clo[r] = 0; m_chi[r] = 0; m_dlo[r] = 0; m_dhi[r] = 0; m_ctrl[r] = 0;
        end
        m_en = 1'b1; m_fault = 1'b0; m_type = 2'd0; m_faddr = 0; m_fpc = 0;
    endtask

    function automatic void model_eval(input bit instr, input logic [31:0] addr,
                                       input logic [3:0] wstrb, input logic [31:0] pc,
                                       output bit allow, output logic [1:0] ftype);
        bit          any_code, granted;
        logic [31:0] who;
        allow = 1'b0; ftype = 2'd0; any_code = 1'b0; granted = 1'b0;
        who = instr ? addr : pc;
        for (int r = 0; r < int'(NUM_REGIONS); r++) begin
            if (m_ctrl[r][0] && who >= m_clo[r] && who <= m_chi[r]) begin
                any_code = 1'b1;
                if (instr) granted |= m_ctrl[r][3];
                else if (addr >= m_dlo[r] && addr <= m_dhi[r])
                    granted |= (wstrb == 4'h0) ? m_ctrl[r][1] : m_ctrl[r][2];
            end
        end
        if (addr >= 4 * MEM_WORDS) ftype = 2'd2;
        else if (!m_en || granted) allow = 1'b1;
        else ftype = any_code ? 2'd1 : 2'd3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        int r;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_we = 1'b0;
        check("cfg_ready after write", 32'(cfg_ready), 32'd1);
        r = int'(a[6:3]);
        if (!a[7] && r < int'(NUM_REGIONS) && !m_ctrl[r][4]) begin
            case (a[2:0])
                3'd0: m_clo[r] = d;
                3'd1: m_chi[r] = d;
                3'd2: m_dlo[r] = d;
                3'd3: m_dhi[r] = d;
                3'd4: m_ctrl[r] = d[4:0];
                default: ;
            endcase
        end
        if (a == 8'h80 && d[0]) m_fault = 1'b0;
        if (a == 8'h83) m_en = d[0];
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg_ready after read", 32'(cfg_ready), 32'd1);
        d = cfg_rdata;
    endtask

    task automatic cpu_access(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] pc);
        bit got;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr[ADDR_WIDTH-1:0];
        cpu_wdata = wdata; cpu_wstrb = wstrb; pc_addr = pc;
        last_cyc = 99; last_wen = 0; last_waddr = 0; last_wdata = 0; last_rdata = 0; got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (mem_wen != 4'h0) begin
                last_wen = mem_wen; last_waddr = 32'(mem_addr); last_wdata = mem_wdata;
            end
            if (cpu_ready) begin
                got = 1'b1; last_cyc = i; last_rdata = cpu_rdata;
            end
        end
        cpu_valid = 1'b0; cpu_wstrb = 4'h0;
    endtask

    task automatic run_and_check(input string tag, input bit instr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] pc, input bit exp_allow,
                                 input logic [1:0] exp_type, input bit do_clear);
        logic [31:0] st, fa, exp_rd;
        int          word;
        cpu_access(instr, addr, wdata, wstrb, pc);
        word = int'(addr[11:2]);
        check({tag, " ready latency"}, 32'(last_cyc), exp_allow ? 32'd3 : 32'd2);
        exp_rd = (exp_allow && wstrb == 4'h0) ? exp_mem[word] : 32'h0;
        check({tag, " cpu_rdata"}, last_rdata, exp_rd);
        if (exp_allow && wstrb != 4'h0) begin
            check({tag, " mem_wen"}, 32'(last_wen), 32'(wstrb));
            check({tag, " mem_addr"}, last_waddr, addr >> 2);
            check({tag, " mem_wdata"}, last_wdata, wdata);
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) exp_mem[word][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            check({tag, " no mem_wen"}, 32'(last_wen), 32'h0);
        end
        if (!exp_allow) begin
            if (!m_fault) begin
                m_type = exp_type; m_faddr = addr; m_fpc = pc;
            end
            m_fault = 1'b1;
        end
        cfg_read(8'h80, st);
        check({tag, " STATUS"}, st, {29'b0, m_type, m_fault});
        check({tag, " irq"}, 32'(irq), 32'(m_fault));
        if (!exp_allow) begin
            cfg_read(8'h81, fa);
            check({tag, " FAULT_ADDR"}, fa, m_faddr);
        end
        if (do_clear && m_fault) cfg_write(8'h80, 32'h1);
    endtask

    typedef struct {
        bit          instr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] pc;
        bit          allow;
        logic [1:0]  ftype;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[13];
        logic [31:0] rd;
        bit          allow;
        logic [1:0]  ft;
        int          ready_seen;

        n_tests = 0; n_fail = 0;
        resetn = 1'b0;
        cpu_valid = 0; cpu_instr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0; pc_addr = 0;
        cfg_valid = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = pattern(i);
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset cpu_ready", 32'(cpu_ready), 32'h0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset mem_wen", 32'(mem_wen), 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset cfg_ready", 32'(cfg_ready), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        resetn = 1'b1;
        cfg_read(8'h80, rd); check("reset STATUS", rd, 32'h0);
        cfg_read(8'h83, rd); check("reset GCTRL", rd, 32'h1);
        cfg_read(8'h04, rd); check("reset region0 CTRL", rd, 32'h0);

        // Permitted write then read back through region 0
        cfg_write(8'h00, 32'h000); cfg_write(8'h01, 32'h0FF);
        cfg_write(8'h02, 32'h200); cfg_write(8'h03, 32'h2FF);
        cfg_write(8'h04, 32'hF);
        run_and_check("r0 write", 1'b0, 32'h204, 32'hDEADBEEF, 4'hF, 32'h10, 1'b1, 2'd0, 1'b1);
        check("r0 write mem_addr 0x81", last_waddr, 32'h81);
        check("r0 write mem_wen 0xF", 32'(last_wen), 32'hF);
        run_and_check("r0 read", 1'b0, 32'h204, 32'h0, 4'h0, 32'h10, 1'b1, 2'd0, 1'b1);
        check("r0 read data", last_rdata, 32'hDEADBEEF);

        // Write without W permission
        cfg_write(8'h04, 32'hB);
        run_and_check("no-W write", 1'b0, 32'h204, 32'h11111111, 4'hF, 32'h10, 1'b0, 2'd1, 1'b0);
        cfg_read(8'h80, rd); check("perm STATUS", rd, 32'h3);
        cfg_read(8'h81, rd); check("perm FAULT_ADDR", rd, 32'h204);
        cfg_read(8'h82, rd); check("perm FAULT_PC", rd, 32'h10);
        check("perm irq", 32'(irq), 32'h1);
        cfg_write(8'h80, 32'h1);
        check("perm irq cleared", 32'(irq), 32'h0);

        // No-region fault, then a second fault before clearing
        cfg_write(8'h04, 32'hF);
        run_and_check("no-region", 1'b0, 32'h200, 32'h0, 4'h0, 32'h400, 1'b0, 2'd3, 1'b0);
        cfg_read(8'h80, rd); check("no-region STATUS", rd, 32'h7);
        run_and_check("second fault", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h10, 1'b0, 2'd2, 1'b0);
        cfg_read(8'h81, rd); check("first fault wins ADDR", rd, 32'h200);
        cfg_read(8'h80, rd); check("first fault wins STATUS", rd, 32'h7);
        cfg_write(8'h80, 32'h6);
        check("STATUS write w/o bit0 keeps irq", 32'(irq), 32'h1);
        cfg_write(8'h80, 32'h1);
        check("STATUS clear drops irq", 32'(irq), 32'h0);

        // Directed table with regions 0, 2 (R only) and 3 (LO>HI)
        cfg_write(8'h10, 32'h100); cfg_write(8'h11, 32'h1FF);
        cfg_write(8'h12, 32'h300); cfg_write(8'h13, 32'h3FF);
        cfg_write(8'h14, 32'h3);
        cfg_write(8'h18, 32'h500); cfg_write(8'h19, 32'h400);
        cfg_write(8'h1A, 32'h0);   cfg_write(8'h1B, 32'hFFF);
        cfg_write(8'h1C, 32'hF);
        vecs[0]  = '{1'b1, 32'h080, 4'h0, 32'h0,   1'b1, 2'd0};
        vecs[1]  = '{1'b1, 32'h150, 4'h0, 32'h0,   1'b0, 2'd1};
        vecs[2]  = '{1'b1, 32'h600, 4'h0, 32'h0,   1'b0, 2'd3};
        vecs[3]  = '{1'b0, 32'h2FC, 4'h0, 32'h0FF, 1'b1, 2'd0};
        vecs[4]  = '{1'b0, 32'h300, 4'h0, 32'h0,   1'b0, 2'd1};
        vecs[5]  = '{1'b0, 32'h300, 4'h0, 32'h100, 1'b1, 2'd0};
        vecs[6]  = '{1'b0, 32'h3FC, 4'h3, 32'h1FF, 1'b0, 2'd1};
        vecs[7]  = '{1'b0, 32'h1000, 4'h0, 32'h10, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 32'hFFC, 4'h0, 32'h10,  1'b0, 2'd1};
        vecs[9]  = '{1'b0, 32'h200, 4'h1, 32'h0,   1'b1, 2'd0};
        vecs[10] = '{1'b1, 32'h480, 4'h0, 32'h0,   1'b0, 2'd3};
        vecs[11] = '{1'b1, 32'h0FF, 4'h0, 32'h0,   1'b1, 2'd0};
        vecs[12] = '{1'b1, 32'h100, 4'h0, 32'h0,   1'b0, 2'd1};
        for (int i = 0; i < 13; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].instr, vecs[i].addr,
                          32'hA0B0C0D0 + 32'(i), vecs[i].wstrb, vecs[i].pc,
                          vecs[i].allow, vecs[i].ftype, 1'b1);
        end

        // Locked region ignores writes until reset
        cfg_write(8'h0C, 32'h11);
        cfg_write(8'h0C, 32'h0);
        cfg_write(8'h08, 32'h1234);
        cfg_read(8'h0C, rd); check("locked CTRL unchanged", rd, 32'h11);
        cfg_read(8'h08, rd); check("locked CODE_LO unchanged", rd, 32'h0);
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk); resetn = 1'b1;
        model_reset();
        cfg_read(8'h0C, rd); check("CTRL after reset", rd, 32'h0);
        cfg_read(8'h04, rd); check("region0 CTRL after reset", rd, 32'h0);

        // MPU disabled: only the SRAM range matters
        cfg_write(8'h83, 32'h0);
        run_and_check("mpu off out of range", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        cfg_read(8'h80, rd); check("range STATUS", rd, 32'h5);
        run_and_check("mpu off 0x300", 1'b0, 32'h300, 32'h12345678, 4'hF, 32'h0, 1'b1, 2'd0, 1'b0);

        // Reset during MEM of a write aborts it (irq is still set from the range fault)
        check("irq before abort", 32'(irq), 32'h1);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 22'h304; cpu_wdata = 32'hCAFEF00D;
        cpu_wstrb = 4'hF; pc_addr = 32'h0;
        repeat (2) @(negedge clk);
        check("abort in MEM mem_wen", 32'(mem_wen), 32'hF);
        #1 resetn = 1'b0;
        #1;
        check("abort mem_wen", 32'(mem_wen), 32'h0);
        check("abort irq", 32'(irq), 32'h0);
        cpu_valid = 1'b0; cpu_wstrb = 4'h0;
        ready_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ready || mem_wen != 4'h0) ready_seen++;
        end
        check("abort no ready/wen", 32'(ready_seen), 32'h0);
        check("abort no SRAM write", sram[10'hC1], exp_mem[10'hC1]);
        resetn = 1'b1;
        model_reset();

        // Randomized accesses against the model
        for (int it = 0; it < 200; it++) begin
            logic [31:0] addr, pc, wd;
            logic [3:0]  ws;
            bit          instr;
            if (it % 40 == 0) begin
                for (int r = 0; r < 4; r++) begin
                    logic [31:0] lo, dlo;
                    lo  = $urandom_range(0, 'h900);
                    dlo = $urandom_range(0, 'hC00);
                    cfg_write(8'(8 * r + 0), lo);
                    cfg_write(8'(8 * r + 1), ($urandom_range(0, 7) == 0 && lo > 0) ? lo - 1
                                             : lo + $urandom_range(0, 'h500));
                    cfg_write(8'(8 * r + 2), dlo);
                    cfg_write(8'(8 * r + 3), dlo + $urandom_range(0, 'h600));
                    cfg_write(8'(8 * r + 4), $urandom_range(0, 15));
                end
                cfg_write(8'h83, ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
            end
            instr = ($urandom_range(0, 3) == 0);
            addr  = $urandom_range(0, 'h13FF) & ~32'h3;
            pc    = $urandom_range(0, 'hE00);
            wd    = $urandom;
            ws    = (instr || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            model_eval(instr, addr, ws, pc, allow, ft);
            run_and_check($sformatf("rand%0d", it), instr, addr, wd, ws, pc, allow, ft,
                          $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_region_mpu.md
MEM_REGION_MPU -- requirements
Module: mem_region_mpu

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving the protected SRAM size in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 22, giving the cpu byte-address width.
REQ-003 The block SHALL have parameter NUM_REGIONS, default 8 (range 1..16), giving the number of region descriptors.
REQ-004 The block SHALL have the following ports, one per line (name direction width meaning):
  clk  in  1  single clock; all state on rising edge.
  resetn  in  1  reset, asynchronous and active-low.
  cpu_valid  in  1  cpu request valid; held until cpu_ready.
  cpu_instr  in  1  request is an instruction fetch.
  cpu_addr  in  ADDR_WIDTH  byte address.
  cpu_wdata  in  32  write data.
  cpu_wstrb  in  4  byte strobes; 0 = read.
  pc_addr  in  32  pc of the issuing instruction (data requests).
  cpu_ready  out  1  one-cycle completion pulse.
  cpu_rdata  out  32  read data, valid with cpu_ready.
  mem_wen  out  4  SRAM byte write enables.
  mem_addr  out  ADDR_WIDTH-2  SRAM word address.
  mem_wdata  out  32  SRAM write data.
  mem_rdata  in  32  SRAM read data, valid one cycle after mem_addr.
  cfg_valid  in  1  config access strobe.
  cfg_we  in  1  config write.
  cfg_addr  in  8  config word index.
  cfg_wdata  in  32  config write data.
  cfg_rdata  out  32  config read data.
  cfg_ready  out  1  config completion pulse.
  irq  out  1  sticky fault interrupt.

Function
REQ-005 Region r SHALL occupy cfg words 8r+0..8r+4: CODE_LO, CODE_HI, DATA_LO, DATA_HI, CTRL{bit0 EN, bit1 R, bit2 W, bit3 X, bit4 LOCK}; bounds are inclusive byte addresses, and a region with LO>HI SHALL never match.
REQ-006 Global registers SHALL be at word 0x80 STATUS{bit0 FAULT, bits2:1 TYPE: 1=perm, 2=range, 3=no-region}, 0x81 FAULT_ADDR, 0x82 FAULT_PC, 0x83 GCTRL{bit0 MPU_EN}; unmapped words SHALL read 0 and ignore writes.
REQ-007 A config access SHALL complete with cfg_ready high for one cycle, the cycle after cfg_valid is sampled; cfg_rdata SHALL be valid in the same cycle.
REQ-008 A write to a region whose LOCK=1 SHALL be ignored; LOCK SHALL clear only on reset.
REQ-009 Writing 1 to STATUS bit0 SHALL clear FAULT and irq; any other STATUS write SHALL be ignored.
REQ-010 The request FSM SHALL have the states IDLE, CHECK, MEM, RESP, with transitions IDLE->CHECK on cpu_valid, CHECK->MEM when allowed, CHECK->RESP when faulted, MEM->RESP, and RESP->IDLE.
REQ-011 A fetch SHALL be allowed when some region has EN&X and cpu_addr in [CODE_LO,CODE_HI].
REQ-012 A data read (cpu_wstrb=0) SHALL be allowed when some region has EN&R, pc_addr in [CODE_LO,CODE_HI], and cpu_addr in [DATA_LO,DATA_HI]; a write SHALL be allowed under the same conditions with W in place of R; the region results SHALL be ORed, with no priority.
REQ-013 The fault TYPE SHALL be: 2 if cpu_addr >= 4*MEM_WORDS, else 3 if no enabled region code-matches, else 1.
REQ-014 When MPU_EN=0, every request with cpu_addr < 4*MEM_WORDS SHALL be allowed.
REQ-015 In MEM, the block SHALL drive mem_addr=cpu_addr[ADDR_WIDTH-1:2], mem_wdata=cpu_wdata and mem_wen=cpu_wstrb for exactly one cycle; mem_wen SHALL be 0 in all other states.
REQ-016 In RESP, cpu_ready SHALL be 1 for one cycle, so that cpu_ready is high exactly 3 cycles after the cycle in which cpu_valid was first sampled in IDLE; cpu_rdata SHALL equal mem_rdata for an allowed read and 0 otherwise.
REQ-017 A fault SHALL perform no SRAM access, SHALL set irq and FAULT, and SHALL still complete with cpu_ready; FAULT_ADDR, FAULT_PC and TYPE SHALL be captured only when FAULT was 0 (first fault wins).
REQ-018 Region registers SHALL be sampled in CHECK, so that a config write completing in the same cycle as CHECK does not affect that request.
REQ-019 A fault and a STATUS clear in the same cycle SHALL leave FAULT=1 and irq=1.

Reset
REQ-020 On resetn=0, asynchronously, all region registers (including LOCK), STATUS, FAULT_ADDR and FAULT_PC SHALL be 0, MPU_EN SHALL be 1, the FSM SHALL be in IDLE, and cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata, cfg_ready, cfg_rdata and irq SHALL be 0.
REQ-021 A reset asserted mid-request SHALL abort the request with no cpu_ready and no further SRAM write.

Verification
REQ-022 The bench SHALL cover: region0 set to code 0x000-0x0FF, data 0x200-0x2FF, EN|R|W|X; a write of 0xDEADBEEF to 0x204 from pc 0x10, then a read -> mem_wen=0xF at mem_addr 0x81, read returns 0xDEADBEEF, cpu_ready 3 cycles after valid.
REQ-023 The bench SHALL cover: the same region with W=0 and a write to 0x204 from pc 0x10 -> no mem_wen, irq=1, STATUS=0x3, FAULT_ADDR=0x204, FAULT_PC=0x10.
REQ-024 The bench SHALL cover: a read at 0x200 from pc 0x400 -> STATUS=0x7; a second fault before clearing leaves FAULT_ADDR unchanged; writing STATUS=1 drops irq.
REQ-025 The bench SHALL cover: region1 with LOCK=1, then a write of 0 to its CTRL -> CTRL reads back unchanged; reset then reads 0.
REQ-026 The bench SHALL cover: MPU_EN=0 and an access to 0x1000 with MEM_WORDS=1024 -> fault TYPE 2; an access to 0x300 -> allowed with no regions configured.
REQ-027 The bench SHALL cover: resetn pulsed low during the MEM state of a write -> mem_wen=0 immediately, no cpu_ready, and irq=0.
